// File: rtl/opentry_pkg.sv
// rtl/opentry_pkg.sv - key codes, FSM state type and key helpers shared by the operand-entry blocks.
package opentry_pkg;

  localparam logic [3:0] KEY_ENTER     = 4'hA;
  localparam logic [3:0] KEY_CLR_ENTRY = 4'hB;
  localparam logic [3:0] KEY_CLR_ALL   = 4'hC;
  localparam logic [3:0] KEY_NEG       = 4'hD;

  typedef enum logic {
    S_ENTRY = 1'b0,
    S_HOLD  = 1'b1
  } opentry_state_t;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'd9;
  endfunction

endpackage

// File: rtl/operand_entry_ctrl_if.sv
// rtl/operand_entry_ctrl_if.sv - operand-set handshake between the entry controller and the datapath.
interface operand_entry_ctrl_if #(
  parameter int DATA_W     = 8,
  parameter int N_OPERANDS = 2
);

  logic                         ops_valid;
  logic                         ops_ready;
  logic [N_OPERANDS*DATA_W-1:0] operands;

  modport master (output ops_valid, output operands, input ops_ready);
  modport slave  (input ops_valid, input operands, output ops_ready);

endinterface

// File: rtl/key_edge_det.sv
// rtl/key_edge_det.sv - one-cycle pulse on the rising edge of key_pressed.
// A key already down when reset releases must be let go before it can fire.
module key_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic key_pressed,
  output logic key_edge
);

  logic key_q;
  logic armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      key_q <= key_pressed;
      armed <= armed | ~key_pressed;
    end
  end

  assign key_edge = key_pressed & ~key_q & armed;

endmodule

// File: rtl/operand_entry_ctrl.sv
// rtl/operand_entry_ctrl.sv - keypad decimal entry into a signed operand set with valid/ready output.
// Optional OPENTRY_BCD_EN adds the entry_bcd digit display port.
module operand_entry_ctrl
  import opentry_pkg::*;
#(
  parameter  int DATA_W     = 8,
  parameter  int MAX_DIGITS = 3,
  parameter  int N_OPERANDS = 2,
  localparam int IDX_W      = (N_OPERANDS > 1) ? $clog2(N_OPERANDS) : 1,
  localparam int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               key_value,
  input  logic                     key_pressed,
  operand_entry_ctrl_if.master     ops_if,
  output logic [DATA_W-2:0]        entry_mag,
  output logic                     entry_neg,
  output logic [IDX_W-1:0]         entry_idx,
  output logic [CNT_W-1:0]         digit_cnt,
  output logic                     err
`ifdef OPENTRY_BCD_EN
  ,
  output logic [4*MAX_DIGITS-1:0]  entry_bcd
`endif
);

  localparam int CAND_W = DATA_W + 4;
  localparam logic [CAND_W-1:0] MAX_MAG = {5'd0, {(DATA_W-1){1'b1}}};

  opentry_state_t    state;
  logic              ops_valid_q;
  logic [DATA_W-1:0] op_q [N_OPERANDS];
  logic              key_edge;

  logic [CAND_W-1:0] cand;
  logic [DATA_W-1:0] mag_ext;
  logic [DATA_W-1:0] commit_val;
  logic              digit_ok;
  logic              last_slot;

  logic do_digit, do_reject, do_neg, do_clr_entry, do_clr_all, do_enter;

  key_edge_det u_key_edge (
    .clk         (clk),
    .rst         (rst),
    .key_pressed (key_pressed),
    .key_edge    (key_edge)
  );

  // Candidate is wide enough that mag*10+9 can never wrap before the range check.
  assign cand       = {5'd0, entry_mag} * CAND_W'(10) + CAND_W'(key_value);
  assign digit_ok   = (digit_cnt < CNT_W'(MAX_DIGITS)) && (cand <= MAX_MAG);
  assign mag_ext    = {1'b0, entry_mag};
  assign commit_val = entry_neg ? -mag_ext : mag_ext;
  assign last_slot  = (entry_idx == IDX_W'(N_OPERANDS - 1));

  always_comb begin
    do_digit     = 1'b0;
    do_reject    = 1'b0;
    do_neg       = 1'b0;
    do_clr_entry = 1'b0;
    do_clr_all   = 1'b0;
    do_enter     = 1'b0;
    if (key_edge) begin
      if (state == S_ENTRY) begin
        do_digit     = is_digit(key_value) && digit_ok;
        do_reject    = is_digit(key_value) && !digit_ok;
        do_neg       = (key_value == KEY_NEG);
        do_clr_entry = (key_value == KEY_CLR_ENTRY);
        do_clr_all   = (key_value == KEY_CLR_ALL);
        do_enter     = (key_value == KEY_ENTER) && (digit_cnt != '0);
      end else begin
        do_clr_all   = (key_value == KEY_CLR_ALL);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_ENTRY;
      ops_valid_q <= 1'b0;
    end else begin
      case (state)
        S_ENTRY: begin
          if (do_enter && last_slot) begin
            state       <= S_HOLD;
            ops_valid_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (ops_if.ops_ready || do_clr_all) begin
            state       <= S_ENTRY;
            ops_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= S_ENTRY;
          ops_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_mag <= '0;
      entry_neg <= 1'b0;
      entry_idx <= '0;
      digit_cnt <= '0;
      err       <= 1'b0;
      for (int i = 0; i < N_OPERANDS; i++) op_q[i] <= '0;
    end else begin
      if (do_clr_all || do_clr_entry || do_enter) begin
        entry_mag <= '0;
        entry_neg <= 1'b0;
        digit_cnt <= '0;
      end
      if (do_clr_all || do_clr_entry) err <= 1'b0;
      if (do_reject) err <= 1'b1;
      if (do_digit) begin
        entry_mag <= cand[DATA_W-2:0];
        digit_cnt <= digit_cnt + CNT_W'(1);
      end
      if (do_neg) entry_neg <= ~entry_neg;
      if (do_clr_all) begin
        entry_idx <= '0;
        for (int i = 0; i < N_OPERANDS; i++) op_q[i] <= '0;
      end
      if (do_enter) begin
        op_q[entry_idx] <= commit_val;
        entry_idx       <= last_slot ? '0 : entry_idx + IDX_W'(1);
      end
    end
  end

`ifdef OPENTRY_BCD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_bcd <= '0;
    end else if (do_clr_all || do_clr_entry || do_enter) begin
      entry_bcd <= '0;
    end else if (do_digit) begin
      entry_bcd <= {entry_bcd[4*MAX_DIGITS-5:0], key_value};
    end
  end
`endif

  assign ops_if.ops_valid = ops_valid_q;

  for (genvar g = 0; g < N_OPERANDS; g++) begin : g_flat
    assign ops_if.operands[g*DATA_W +: DATA_W] = op_q[g];
  end

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// tb/tb_operand_entry_ctrl.sv - directed and random key sequences on a narrow and a wide instance,
// compared every cycle against a keypad-level reference model.
module tb_operand_entry_ctrl;

  localparam int AW = 8,  AD = 3, AN = 2;
  localparam int BW = 16, BD = 4, BN = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key = 4'd0;
  logic       kp  = 1'b0;
  logic       rdy = 1'b0;

  always #5 clk = ~clk;

  operand_entry_ctrl_if #(.DATA_W(AW), .N_OPERANDS(AN)) if_a ();
  operand_entry_ctrl_if #(.DATA_W(BW), .N_OPERANDS(BN)) if_b ();
  assign if_a.ops_ready = rdy;
  assign if_b.ops_ready = rdy;

  logic [AW-2:0] a_mag; logic a_neg; logic [0:0] a_idx; logic [1:0] a_cnt; logic a_err;
  logic [BW-2:0] b_mag; logic b_neg; logic [1:0] b_idx; logic [2:0] b_cnt; logic b_err;

  operand_entry_ctrl #(.DATA_W(AW), .MAX_DIGITS(AD), .N_OPERANDS(AN)) u_a (
    .clk(clk), .rst(rst), .key_value(key), .key_pressed(kp), .ops_if(if_a.master),
    .entry_mag(a_mag), .entry_neg(a_neg), .entry_idx(a_idx), .digit_cnt(a_cnt), .err(a_err)
  );

  operand_entry_ctrl #(.DATA_W(BW), .MAX_DIGITS(BD), .N_OPERANDS(BN)) u_b (
    .clk(clk), .rst(rst), .key_value(key), .key_pressed(kp), .ops_if(if_b.master),
    .entry_mag(b_mag), .entry_neg(b_neg), .entry_idx(b_idx), .digit_cnt(b_cnt), .err(b_err)
  );

  // Reference model, one slot per instance: 0 = narrow, 1 = wide.
  int cfg_w [2] = '{AW, BW};
  int cfg_d [2] = '{AD, BD};
  int cfg_n [2] = '{AN, BN};
  int m_mag [2];
  bit m_neg [2];
  int m_idx [2];
  int m_cnt [2];
  bit m_err [2];
  int m_ops [2][4];
  bit m_hold[2];
  bit m_prev[2];

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear_all(input int u);
    m_mag[u] = 0; m_neg[u] = 0; m_cnt[u] = 0; m_err[u] = 0; m_idx[u] = 0;
    for (int i = 0; i < 4; i++) m_ops[u][i] = 0;
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      model_clear_all(u);
      m_hold[u] = 0;
      m_prev[u] = 1;   // a key seen down right after reset counts as held through it
    end
  endtask

  task automatic model_step(input int u);
    int maxmag, k, v;
    bit e;
    maxmag = (1 << (cfg_w[u] - 1)) - 1;
    k = int'(key);
    e = kp && !m_prev[u];
    m_prev[u] = kp;
    if (m_hold[u]) begin
      if (rdy) m_hold[u] = 0;
      if (e && k == 12) begin
        model_clear_all(u);
        m_hold[u] = 0;
      end
    end else if (e) begin
      if (k <= 9) begin
        v = m_mag[u] * 10 + k;
        if (m_cnt[u] < cfg_d[u] && v <= maxmag) begin
          m_mag[u] = v;
          m_cnt[u]++;
        end else begin
          m_err[u] = 1;
        end
      end else if (k == 13) begin
        m_neg[u] = !m_neg[u];
      end else if (k == 11) begin
        m_mag[u] = 0; m_neg[u] = 0; m_cnt[u] = 0; m_err[u] = 0;
      end else if (k == 12) begin
        model_clear_all(u);
      end else if (k == 10 && m_cnt[u] != 0) begin
        m_ops[u][m_idx[u]] = m_neg[u] ? -m_mag[u] : m_mag[u];
        m_mag[u] = 0; m_neg[u] = 0; m_cnt[u] = 0;
        if (m_idx[u] == cfg_n[u] - 1) begin
          m_idx[u] = 0;
          m_hold[u] = 1;
        end else begin
          m_idx[u]++;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("a_valid", 32'(if_a.ops_valid), 32'(m_hold[0]));
    for (int i = 0; i < AN; i++)
      check($sformatf("a_op%0d", i), 32'(if_a.operands[i*AW +: AW]), m_ops[0][i] & 32'hFF);
    check("a_mag", 32'(a_mag), m_mag[0]);
    check("a_neg", 32'(a_neg), 32'(m_neg[0]));
    check("a_idx", 32'(a_idx), m_idx[0]);
    check("a_cnt", 32'(a_cnt), m_cnt[0]);
    check("a_err", 32'(a_err), 32'(m_err[0]));
    check("b_valid", 32'(if_b.ops_valid), 32'(m_hold[1]));
    for (int i = 0; i < BN; i++)
      check($sformatf("b_op%0d", i), 32'(if_b.operands[i*BW +: BW]), m_ops[1][i] & 32'hFFFF);
    check("b_mag", 32'(b_mag), m_mag[1]);
    check("b_neg", 32'(b_neg), 32'(m_neg[1]));
    check("b_idx", 32'(b_idx), m_idx[1]);
    check("b_cnt", 32'(b_cnt), m_cnt[1]);
    check("b_err", 32'(b_err), 32'(m_err[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    compare_all();
  endtask

  task automatic press(input logic [3:0] k, input int hold_cyc);
    key = k;
    kp  = 1'b1;
    repeat (hold_cyc) tick();
    kp  = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_a_valid", 32'(if_a.ops_valid), 0);
    check("rst_a_ops", 32'(if_a.operands), 0);
    check("rst_a_entry", {a_mag, a_neg, a_idx, a_cnt, a_err}, 0);
    check("rst_b_ops", 32'(if_b.operands[31:0]), 0);
    check("rst_b_entry", {b_mag, b_neg, b_idx, b_cnt, b_err}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    do_reset();
    tick();
    compare_all();

    // Two-operand set 12, 7
    press(4'd1, 1); press(4'd2, 1); press(4'hA, 1); press(4'd7, 1);
    key = 4'hA; kp = 1'b1; tick();
    check("t1_valid", 32'(if_a.ops_valid), 1);
    check("t1_op0", 32'(if_a.operands[7:0]), 12);
    check("t1_op1", 32'(if_a.operands[15:8]), 7);
    check("t1_idx", 32'(a_idx), 0);
    kp = 1'b0; tick();
    rdy = 1'b1; tick(); rdy = 1'b0;
    check("t1_released", 32'(if_a.ops_valid), 0);

    // Range overflow then clear-entry
    press(4'd1, 1); press(4'd2, 1); press(4'd8, 1);
    check("t2_mag", 32'(a_mag), 12);
    check("t2_err", 32'(a_err), 1);
    press(4'hB, 1);
    check("t2_err_clr", 32'(a_err), 0);
    check("t2_cnt_clr", 32'(a_cnt), 0);

    // Negative operand, double sign toggle, then the set goes to hold
    press(4'hD, 1); press(4'd4, 1); press(4'd5, 1); press(4'hA, 1);
    check("t3_op0", 32'(if_a.operands[7:0]), 32'hD3);
    press(4'hD, 1); press(4'hD, 1); press(4'd3, 1);
    check("t3_mag", 32'(a_mag), 3);
    check("t3_neg", 32'(a_neg), 0);
    press(4'hA, 1);

    // Hold: keys other than CLR_ALL ignored while ops_ready is low
    repeat (4) tick();
    press(4'd5, 2);
    repeat (3) tick();
    check("t4_valid", 32'(if_a.ops_valid), 1);
    check("t4_ops", 32'(if_a.operands), 32'h03D3);
    check("t4_mag", 32'(a_mag), 0);
    rdy = 1'b1; tick(); rdy = 1'b0;
    check("t4_released", 32'(if_a.ops_valid), 0);
    check("t4_ops_kept", 32'(if_a.operands), 32'h03D3);

    // Long hold yields one digit
    press(4'd9, 20);
    check("t5_mag", 32'(a_mag), 9);
    check("t5_cnt", 32'(a_cnt), 1);
    press(4'hC, 1);
    check("t5_clr_all", 32'(if_a.operands), 0);

    // Most negative legal value
    press(4'hD, 1); press(4'd1, 1); press(4'd2, 1); press(4'd7, 1); press(4'hA, 1);
    check("t_min_op0", 32'(if_a.operands[7:0]), 32'h81);

    // Reset mid-entry at idx 1, with a key held through the reset
    press(4'd4, 1); press(4'd2, 1);
    check("t6_idx_pre", 32'(a_idx), 1);
    key = 4'd9; kp = 1'b1;
    do_reset();
    repeat (3) tick();
    kp = 1'b0; tick();
    check("t6_held_no_action", 32'(a_cnt), 0);

    // Wide instance: four 9s fit, a fifth digit is refused
    press(4'd9, 1); press(4'd9, 1); press(4'd9, 1); press(4'd9, 1);
    check("t6_wide_mag", 32'(b_mag), 9999);
    check("t6_wide_cnt", 32'(b_cnt), 4);
    press(4'd9, 1);
    check("t6_wide_err", 32'(b_err), 1);
    press(4'hC, 1);

    // Hold with CLR_ALL and ops_ready in the same cycle
    press(4'd3, 1); press(4'hA, 1); press(4'd4, 1); press(4'hA, 1);
    key = 4'hC; kp = 1'b1; rdy = 1'b1; tick(); kp = 1'b0; rdy = 1'b0; tick();
    check("t7_valid", 32'(if_a.ops_valid), 0);
    check("t7_ops", 32'(if_a.operands), 0);

    // Random key traffic
    for (int n = 0; n < 600; n++) begin
      int r;
      logic [3:0] k;
      r = $urandom_range(0, 19);
      k = (r < 12) ? 4'(r % 10) : 4'($urandom_range(10, 15));
      rdy = ($urandom_range(0, 3) == 0);
      key = k;
      kp  = 1'b1;
      repeat ($urandom_range(1, 3)) tick();
      kp  = 1'b0;
      repeat ($urandom_range(1, 2)) tick();
      if ($urandom_range(0, 99) == 0) do_reset();
    end
    rdy = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
